// File: rtl/coeff_stats_if.sv
// coeff_stats_if: block coefficient stream and statistics handshake bundle
//  master: drives blk_abort, coef_in, coef_valid, stat_ready
//  slave : drives coef_ready, stat_valid, total_coeff, trailing_ones,
//          t1_signs, total_zeros, coeff_token_addr
interface coeff_stats_if #(parameter int CW = 16) ();
  logic          blk_abort;
  logic [CW-1:0] coef_in;
  logic          coef_valid;
  logic          coef_ready;
  logic          stat_valid;
  logic          stat_ready;
  logic [4:0]    total_coeff;
  logic [1:0]    trailing_ones;
  logic [2:0]    t1_signs;
  logic [3:0]    total_zeros;
  logic [6:0]    coeff_token_addr;
  modport master (
    output blk_abort, coef_in, coef_valid, stat_ready,
    input  coef_ready, stat_valid, total_coeff, trailing_ones, t1_signs,
           total_zeros, coeff_token_addr
  );
  modport slave (
    input  blk_abort, coef_in, coef_valid, stat_ready,
    output coef_ready, stat_valid, total_coeff, trailing_ones, t1_signs,
           total_zeros, coeff_token_addr
  );
endinterface

// File: rtl/coeff_stats_scanner.sv
// coeff_stats_scanner: CAVLC block statistics (TotalCoeff, TrailingOnes, signs, TotalZeros)
//  clk   : rising-edge clock
//  rst_n : asynchronous active-low reset
//  bus   : coeff_stats_if.slave -- reverse zig-zag coefficient stream in,
//          block statistics and coeff_token address out (valid in HOLD)
module coeff_stats_scanner #(
  parameter int CW        = 16,
  parameter int NUM_COEFF = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  coeff_stats_if.slave   bus
);
  localparam logic [0:0] S_SCAN = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;
  logic [0:0] state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [4:0] tc_q, tc_d;
  logic [1:0] t1_q, t1_d;
  logic [2:0] sg_q, sg_d;
  logic [3:0] tz_q, tz_d;
  logic       closed_q, closed_d;
  logic       seen_q, seen_d;
  logic       nz, is_one, clr, take;
  assign nz     = bus.coef_in != '0;
  assign is_one = bus.coef_in == CW'(1) || bus.coef_in == '1;
  // abort wins over everything; a completed handshake also returns to an empty block
  assign clr    = bus.blk_abort || (state_q == S_HOLD && bus.stat_ready);
  assign take   = state_q == S_SCAN && bus.coef_valid;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tc_d     = tc_q;
    t1_d     = t1_q;
    sg_d     = sg_q;
    tz_d     = tz_q;
    closed_d = closed_q;
    seen_d   = seen_q;
    if (clr) begin
      state_d  = S_SCAN;
      idx_d    = '0;
      tc_d     = '0;
      t1_d     = '0;
      sg_d     = '0;
      tz_d     = '0;
      closed_d = 1'b0;
      seen_d   = 1'b0;
    end else if (take) begin
      idx_d   = idx_q + 5'd1;
      state_d = idx_q == 5'(NUM_COEFF - 1) ? S_HOLD : S_SCAN;
      if (nz) begin
        tc_d   = tc_q + 5'd1;
        seen_d = 1'b1;
        // the trailing-ones run stays open across zeros; any other non-zero ends it
        if (!closed_q && is_one && t1_q != 2'd3) begin
          sg_d[t1_q] = bus.coef_in[CW-1];
          t1_d       = t1_q + 2'd1;
        end else begin
          closed_d = 1'b1;
        end
      end else if (seen_q) begin
        tz_d = tz_q + 4'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_SCAN;
      idx_q    <= '0;
      tc_q     <= '0;
      t1_q     <= '0;
      sg_q     <= '0;
      tz_q     <= '0;
      closed_q <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tc_q     <= tc_d;
      t1_q     <= t1_d;
      sg_q     <= sg_d;
      tz_q     <= tz_d;
      closed_q <= closed_d;
      seen_q   <= seen_d;
    end
  end
  assign bus.coef_ready       = state_q == S_SCAN;
  assign bus.stat_valid       = state_q == S_HOLD;
  assign bus.total_coeff      = tc_q;
  assign bus.trailing_ones    = t1_q;
  assign bus.t1_signs         = sg_q;
  assign bus.total_zeros      = tz_q;
  assign bus.coeff_token_addr = {t1_q, tc_q};
endmodule

// File: tb/tb_coeff_stats_scanner.sv
// tb_coeff_stats_scanner: directed and randomized block checks against a zig-zag model
module tb_coeff_stats_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nerr = 0;
  logic signed [15:0] cur [16];
  int e_tc, e_t1, e_tz;
  logic [2:0] e_sg;
  coeff_stats_if #(.CW(16)) bus ();
  coeff_stats_scanner #(.CW(16), .NUM_COEFF(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // cur[i] holds zig-zag scan position i; statistics derived from positions directly
  function automatic void model();
    int last;
    last = -1;
    e_tc = 0; e_t1 = 0; e_tz = 0; e_sg = '0;
    for (int i = 0; i < 16; i++) if (cur[i] != 0) begin e_tc++; last = i; end
    for (int i = 0; i < last; i++) if (cur[i] == 0) e_tz++;
    for (int i = last; i >= 0; i--) begin
      if (cur[i] == 0) continue;
      if ((cur[i] == 1 || cur[i] == -1) && e_t1 < 3) begin
        e_sg[e_t1] = cur[i] < 0;
        e_t1++;
      end else break;
    end
  endfunction
  task automatic idle_out(input string tag);
    chk({tag, " coef_ready"}, bus.coef_ready, 1);
    chk({tag, " stat_valid"}, bus.stat_valid, 0);
    chk({tag, " tc"}, bus.total_coeff, 0);
    chk({tag, " t1"}, bus.trailing_ones, 0);
    chk({tag, " signs"}, bus.t1_signs, 0);
    chk({tag, " tz"}, bus.total_zeros, 0);
    chk({tag, " addr"}, bus.coeff_token_addr, 0);
  endtask
  task automatic send(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        bus.coef_valid = 1'b0;
        bus.coef_in = 16'($urandom);
        @(posedge clk); #1;
      end
      bus.coef_valid = 1'b1;
      bus.coef_in = cur[15 - k];
      @(posedge clk); #1;
    end
    bus.coef_valid = 1'b0;
  endtask
  task automatic expect_stats(input string tag, input int tc, input int t1, input int sg, input int tz);
    int w;
    w = 0;
    while (!bus.stat_valid && w < 4) begin @(posedge clk); #1; w++; end
    chk({tag, " stat_valid"}, bus.stat_valid, 1);
    chk({tag, " coef_ready"}, bus.coef_ready, 0);
    chk({tag, " tc"}, bus.total_coeff, tc);
    chk({tag, " t1"}, bus.trailing_ones, t1);
    chk({tag, " signs"}, bus.t1_signs, sg);
    chk({tag, " tz"}, bus.total_zeros, tz);
    chk({tag, " addr"}, bus.coeff_token_addr, t1 * 32 + tc);
  endtask
  task automatic release_stats();
    bus.stat_ready = 1'b1;
    @(posedge clk); #1;
    bus.stat_ready = 1'b0;
  endtask
  task automatic load_s1();
    for (int i = 0; i < 16; i++) cur[i] = 0;
    cur[1] = 3; cur[2] = -1; cur[5] = -1; cur[6] = 1; cur[8] = 1;
  endtask
  initial begin
    bus.blk_abort = 1'b0;
    bus.coef_in = '0;
    bus.coef_valid = 1'b0;
    bus.stat_ready = 1'b0;
    #1;
    idle_out("reset_async");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_out("reset");
    load_s1();
    send(16, 0);
    expect_stats("s1", 5, 3, 3'b100, 4);
    release_stats();
    for (int i = 0; i < 16; i++) cur[i] = 0;
    send(16, 1);
    expect_stats("s2_zero", 0, 0, 0, 0);
    release_stats();
    for (int i = 0; i < 16; i++) cur[i] = 1;
    send(16, 0);
    expect_stats("s3_ones", 16, 3, 0, 0);
    release_stats();
    for (int i = 0; i < 16; i++) cur[i] = 0;
    cur[0] = -1; cur[1] = 2;
    send(16, 0);
    expect_stats("s4_two", 2, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      bus.coef_valid = 1'b1;
      bus.coef_in = 16'sd1;
      @(posedge clk); #1;
      chk("s5 hold tc", bus.total_coeff, 2);
      chk("s5 hold t1", bus.trailing_ones, 0);
      chk("s5 hold coef_ready", bus.coef_ready, 0);
      chk("s5 hold stat_valid", bus.stat_valid, 1);
    end
    bus.coef_valid = 1'b0;
    release_stats();
    load_s1();
    send(16, 1);
    expect_stats("s5_after", 5, 3, 3'b100, 4);
    release_stats();
    for (int i = 0; i < 16; i++) cur[i] = (i % 3 == 0) ? -16'sd1 : 16'sd0;
    send(7, 0);
    bus.blk_abort = 1'b1;
    bus.coef_valid = 1'b1;
    @(posedge clk); #1;
    bus.blk_abort = 1'b0;
    bus.coef_valid = 1'b0;
    idle_out("s6_abort");
    load_s1();
    send(16, 0);
    expect_stats("s6_after_abort", 5, 3, 3'b100, 4);
    #2 rst_n = 1'b0;
    #1;
    idle_out("s6_rst_hold");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send(16, 0);
    expect_stats("s6_after_rst", 5, 3, 3'b100, 4);
    release_stats();
    for (int b = 0; b < 40; b++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 99) < dens) begin
          case ($urandom_range(0, 5))
            0, 1, 2: cur[i] = $urandom_range(0, 1) ? 16'sd1 : -16'sd1;
            3: cur[i] = $urandom_range(0, 1) ? 16'sd2 : -16'sd2;
            default: cur[i] = 16'($urandom);
          endcase
        end else cur[i] = 0;
      end
      model();
      send(16, 1);
      expect_stats($sformatf("rand%0d", b), e_tc, e_t1, e_sg, e_tz);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      release_stats();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
